uart_tx_param: RTL

Parametrised UART transmitter, the next generation of the fixed 8-bit/odd-parity/9600-baud UART transmit path. It pulls words from a first-word-fall-through TX FIFO and serialises them LSB-first on txd with a configurable frame: data bits, parity mode, stop-bit count and clocks-per-bit. It sits between the SBUF-side TX FIFO and the pad. A frame-done pulse feeds the TI interrupt logic.

---
 rtl/uart_tx_param.sv | 98 +++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter that pops words from a FWFT FIFO and frames them on txd.
// Define UART_TX_CTS_EN to add the active-low cts_n input that gates FIFO pops.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int DIV_NUM   = 16
) (
    input  logic                 clk_tx,
    input  logic                 rst_n,
`ifdef UART_TX_CTS_EN
    input  logic                 cts_n,
`endif
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 fifo_empty,
    output logic                 r_en,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int BW = (DIV_NUM > 2) ? $clog2(DIV_NUM) : 1;
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(DIV_NUM - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]           r_state;
    logic [BW-1:0]        r_baud;
    logic [CW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par;
    logic                 r_txd;
    logic                 w_cts;
    logic                 w_tick;

`ifdef UART_TX_CTS_EN
    assign w_cts = ~cts_n;
`else
    assign w_cts = 1'b1;
`endif
    assign w_tick  = r_baud == BAUD_MAX;
    // gated by rst_n so the FIFO never loses a word while the transmitter is held in reset
    assign r_en    = rst_n & (r_state == IDLE) & ~fifo_empty & w_cts;
    assign txd     = r_txd;
    assign busy    = r_state != IDLE;
    assign tx_done = (r_state == STOP) & w_tick & (r_bit == STOP_LAST);

    always_ff @(posedge clk_tx) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shreg <= '1;
            r_par   <= 1'b1;
            r_txd   <= 1'b1;
        end else begin
            r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE: if (r_en) begin
                    r_state <= START;
                    r_shreg <= tx_data;
                    r_par   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                    r_txd   <= 1'b0;
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_txd   <= r_shreg[0];
                    r_shreg <= {1'b1, r_shreg[DATA_BITS-1:1]};
                end
                DATA: if (w_tick) begin
                    if (r_bit == DATA_LAST) begin
                        r_bit   <= '0;
                        r_state <= (PARITY != 0) ? PAR : STOP;
                        r_txd   <= (PARITY != 0) ? r_par : 1'b1;
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_txd   <= r_shreg[0];
                        r_shreg <= {1'b1, r_shreg[DATA_BITS-1:1]};
                    end
                end
                PAR: if (w_tick) begin
                    r_state <= STOP;
                    r_txd   <= 1'b1;
                end
                STOP: if (w_tick) begin
                    r_bit   <= (r_bit == STOP_LAST) ? '0 : r_bit + 1'b1;
                    r_state <= (r_bit == STOP_LAST) ? IDLE : STOP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
